// File: rtl/hsi_line_pkg.sv
// Shared types and helpers for the HSI command/data line selector.
// Line indices are at most 3 bits wide (up to 8 lines); modular sums are
// formed in 5 bits so a + b never overflows before the wrap correction.
package hsi_line_pkg;

   // Width of the consecutive-failure counter.
   localparam int FAIL_CNT_W   = 4;

   // Largest supported line index width plus two guard bits.
   localparam int LINE_IDX_W   = 3;
   localparam int LINE_ARITH_W = LINE_IDX_W + 2;

   // Exchange routing state: on the home line, or temporarily moved away.
   typedef enum logic {
      HOME = 1'b0,
      TEMP = 1'b1
   } line_st_t;

   // Modular index addition: (a + b) mod n, assuming a < n and b < n.
   // A single conditional subtraction is enough under that precondition.
   function automatic logic [LINE_ARITH_W-1:0] line_add(
      input logic [LINE_ARITH_W-1:0] a,
      input logic [LINE_ARITH_W-1:0] b,
      input logic [LINE_ARITH_W-1:0] n
   );
      logic [LINE_ARITH_W-1:0] s;
      s = a + b;
      if (s >= n) begin
         s = s - n;
      end
      return s;
   endfunction

endpackage

// File: rtl/hsi_fail_cnt.sv
// Consecutive-failure counter for the current home line.
// Every failed exchange (inc) counts up; a good reply (clr) resets the run.
// Reaching FAIL_LIMIT raises a combinational limit pulse in the same cycle
// as the increment and the counter restarts from zero on that edge.
module hsi_fail_cnt
   import hsi_line_pkg::*;
#(
   parameter int FAIL_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  sync_clr,
   input  logic                  inc,
   input  logic                  clr,
   output logic [FAIL_CNT_W-1:0] cnt,
   output logic                  limit_hit
);

   logic [FAIL_CNT_W-1:0] r_cnt;
   logic [FAIL_CNT_W-1:0] w_cnt_inc;
   logic [FAIL_CNT_W-1:0] w_cnt_next;

   assign w_cnt_inc = r_cnt + FAIL_CNT_W'(1);
   assign limit_hit = inc && (w_cnt_inc == FAIL_CNT_W'(FAIL_LIMIT));
   assign cnt       = r_cnt;

   // Next count: an increment outranks a clear arriving in the same cycle.
   always_comb begin
      w_cnt_next = r_cnt;
      if (sync_clr) begin
         w_cnt_next = '0;
      end else if (inc) begin
         w_cnt_next = limit_hit ? '0 : w_cnt_inc;
      end else if (clr) begin
         w_cnt_next = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

endmodule

// File: rtl/hsi_line_sel.sv
// HSI master command/data line selector.
// Routes the coder stream onto one of N_LINES redundant command lines and
// selects the matching reply data line. A failed exchange moves traffic to
// the next line for one exchange window; FAIL_LIMIT failures in a row move
// the home line permanently. Wrapping the permanent offset back to zero
// means every line has been tried and raises all_failed.
module hsi_line_sel
   import hsi_line_pkg::*;
#(
   parameter  int N_LINES    = 2,
   parameter  int FAIL_LIMIT = 3,
   localparam int LW         = $clog2(N_LINES)
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  sync_clr,
   input  logic [LW-1:0]         base_line,
   input  logic                  switch_req,
   input  logic                  frame_to_reply_end,
   input  logic                  rx_ok,
   input  logic                  cd_q,
   input  logic [N_LINES-1:0]    dat,
   output logic [N_LINES-1:0]    com,
   output logic                  dat_q,
   output logic [LW-1:0]         act_line,
   output logic                  temp_active,
   output logic [LW-1:0]         sticky_off,
   output logic [FAIL_CNT_W-1:0] fail_cnt,
   output logic                  all_failed
);

   // Line count in the width used for modular index arithmetic.
   localparam logic [LINE_ARITH_W-1:0] C_N = LINE_ARITH_W'(N_LINES);

   // Registered state.
   line_st_t      r_state;
   logic [LW-1:0] r_temp_off;
   logic [LW-1:0] r_sticky_off;
   logic          r_all_failed;
   logic [LW-1:0] r_act_line;

   // Next-state values.
   line_st_t      w_state_next;
   logic [LW-1:0] w_temp_off_next;
   logic [LW-1:0] w_sticky_next;
   logic          w_all_failed_next;
   logic [LW-1:0] w_act_next;

   // Helpers.
   logic [LW-1:0] w_base_eff;
   logic [LW-1:0] w_sticky_inc;
   logic [LW-1:0] w_temp_inc;
   logic [LW-1:0] w_temp_step;
   logic [LW-1:0] w_home_next;
   logic          w_limit_hit;
   logic [N_LINES-1:0] w_dat_hit;

   //------------------------------------------------------------------
   // Failure counter
   //------------------------------------------------------------------
   hsi_fail_cnt #(
      .FAIL_LIMIT (FAIL_LIMIT)
   ) u_fail_cnt (
      .clk       (clk),
      .n_rst     (n_rst),
      .sync_clr  (sync_clr),
      .inc       (switch_req),
      .clr       (rx_ok),
      .cnt       (fail_cnt),
      .limit_hit (w_limit_hit)
   );

   //------------------------------------------------------------------
   // Index arithmetic
   //------------------------------------------------------------------
   // An out-of-range configured home line falls back to line 0.
   assign w_base_eff = (LINE_ARITH_W'(base_line) < C_N) ? base_line : '0;

   assign w_sticky_inc = LW'(line_add(LINE_ARITH_W'(r_sticky_off),
                                      LINE_ARITH_W'(1), C_N));
   assign w_temp_inc   = LW'(line_add(LINE_ARITH_W'(r_temp_off),
                                      LINE_ARITH_W'(1), C_N));
   // A temporary offset of 0 would land back on the failing home line,
   // so the walk wraps from N-1 straight to 1.
   assign w_temp_step  = (w_temp_inc == '0) ? LW'(1) : w_temp_inc;

   // act_line is rebuilt from the next offsets every cycle, so a change of
   // base_line shows up on the next edge without disturbing any counters.
   // After sync_clr both offsets are 0 and act_line lands on the home line.
   assign w_home_next = LW'(line_add(LINE_ARITH_W'(w_base_eff),
                                     LINE_ARITH_W'(w_sticky_next), C_N));
   assign w_act_next  = LW'(line_add(LINE_ARITH_W'(w_home_next),
                                     LINE_ARITH_W'(w_temp_off_next), C_N));

   //------------------------------------------------------------------
   // FSM
   //------------------------------------------------------------------
   // State and offset registers; n_rst parks everything on line 0.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= HOME;
         r_temp_off   <= '0;
         r_sticky_off <= '0;
         r_all_failed <= 1'b0;
         r_act_line   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_temp_off   <= w_temp_off_next;
         r_sticky_off <= w_sticky_next;
         r_all_failed <= w_all_failed_next;
         r_act_line   <= w_act_next;
      end
   end

   // Next-state logic: sync_clr first, then switch_req, then window close.
   always_comb begin
      w_state_next      = r_state;
      w_temp_off_next   = r_temp_off;
      w_sticky_next     = r_sticky_off;
      w_all_failed_next = r_all_failed;
      if (sync_clr) begin
         w_state_next      = HOME;
         w_temp_off_next   = '0;
         w_sticky_next     = '0;
         w_all_failed_next = 1'b0;
      end else if (switch_req) begin
         if (w_limit_hit) begin
            // Permanent move: new home line, temporary detour abandoned.
            w_state_next    = HOME;
            w_temp_off_next = '0;
            w_sticky_next   = w_sticky_inc;
            if (w_sticky_inc == '0) begin
               w_all_failed_next = 1'b1;
            end
         end else begin
            unique case (r_state)
               HOME: begin
                  w_state_next    = TEMP;
                  w_temp_off_next = LW'(1);
               end
               TEMP: begin
                  w_temp_off_next = w_temp_step;
               end
               default: begin
                  w_state_next    = HOME;
                  w_temp_off_next = '0;
               end
            endcase
         end
      end else if (frame_to_reply_end && (r_state == TEMP)) begin
         // Exchange window closed without a new failure: back home.
         w_state_next    = HOME;
         w_temp_off_next = '0;
      end
   end

   // Status outputs derived from the registered state.
   always_comb begin
      temp_active = (r_state == TEMP);
      act_line    = r_act_line;
      sticky_off  = r_sticky_off;
      all_failed  = r_all_failed;
   end

   //------------------------------------------------------------------
   // Line muxes
   //------------------------------------------------------------------
   // Only the active command line carries cd_q; idle lines sit at 1.
   // The reply mux is an AND-OR tree so a non-power-of-two line count
   // never indexes past the top of dat.
   genvar gi;
   generate
      for (gi = 0; gi < N_LINES; gi++) begin : g_line
         assign com[gi]       = (r_act_line == LW'(gi)) ? cd_q : 1'b1;
         assign w_dat_hit[gi] = (r_act_line == LW'(gi)) & dat[gi];
      end
   endgenerate

   assign dat_q = |w_dat_hit;

endmodule

// File: tb/tb_hsi_line_sel.sv
// Bench for hsi_line_sel: three instances (4 lines/limit 3, 2 lines/limit 1,
// 3 lines/limit 2) share one stimulus stream. Each has a line-number
// reference model; directed scenarios compare against hand-derived values.
module tb_hsi_line_sel;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       sync_clr;
   logic [1:0] base;
   logic       switch_req;
   logic       fe;
   logic       rx_ok;
   logic       cd_q;
   logic [3:0] dat;

   logic [3:0] com_a;  logic datq_a; logic [1:0] act_a; logic tmp_a;
   logic [1:0] sticky_a; logic [3:0] fcnt_a; logic allf_a;
   logic [1:0] com_b;  logic datq_b; logic [0:0] act_b; logic tmp_b;
   logic [0:0] sticky_b; logic [3:0] fcnt_b; logic allf_b;
   logic [2:0] com_c;  logic datq_c; logic [1:0] act_c; logic tmp_c;
   logic [1:0] sticky_c; logic [3:0] fcnt_c; logic allf_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hsi_line_sel #(.N_LINES(4), .FAIL_LIMIT(3)) u_dut_a (
      .clk(clk), .n_rst(n_rst), .sync_clr(sync_clr), .base_line(base),
      .switch_req(switch_req), .frame_to_reply_end(fe), .rx_ok(rx_ok),
      .cd_q(cd_q), .dat(dat), .com(com_a), .dat_q(datq_a), .act_line(act_a),
      .temp_active(tmp_a), .sticky_off(sticky_a), .fail_cnt(fcnt_a),
      .all_failed(allf_a));

   hsi_line_sel #(.N_LINES(2), .FAIL_LIMIT(1)) u_dut_b (
      .clk(clk), .n_rst(n_rst), .sync_clr(sync_clr), .base_line(base[0:0]),
      .switch_req(switch_req), .frame_to_reply_end(fe), .rx_ok(rx_ok),
      .cd_q(cd_q), .dat(dat[1:0]), .com(com_b), .dat_q(datq_b), .act_line(act_b),
      .temp_active(tmp_b), .sticky_off(sticky_b), .fail_cnt(fcnt_b),
      .all_failed(allf_b));

   hsi_line_sel #(.N_LINES(3), .FAIL_LIMIT(2)) u_dut_c (
      .clk(clk), .n_rst(n_rst), .sync_clr(sync_clr), .base_line(base),
      .switch_req(switch_req), .frame_to_reply_end(fe), .rx_ok(rx_ok),
      .cd_q(cd_q), .dat(dat[2:0]), .com(com_c), .dat_q(datq_c), .act_line(act_c),
      .temp_active(tmp_c), .sticky_off(sticky_c), .fail_cnt(fcnt_c),
      .all_failed(allf_c));

   // Packed status snapshots {act, temp_active, sticky, fail_cnt, all_failed}.
   logic [9:0] snap_a;
   logic [7:0] snap_b;
   logic [9:0] snap_c;
   assign snap_a = {act_a, tmp_a, sticky_a, fcnt_a, allf_a};
   assign snap_b = {act_b, tmp_b, sticky_b, fcnt_b, allf_b};
   assign snap_c = {act_c, tmp_c, sticky_c, fcnt_c, allf_c};

   // Observed values per instance, for the random comparison loop.
   int obs_act[3], obs_tmp[3], obs_sticky[3], obs_fcnt[3];
   int obs_allf[3], obs_com[3], obs_datq[3];
   always_comb begin
      obs_act[0] = int'(act_a); obs_act[1] = int'(act_b); obs_act[2] = int'(act_c);
      obs_tmp[0] = int'(tmp_a); obs_tmp[1] = int'(tmp_b); obs_tmp[2] = int'(tmp_c);
      obs_sticky[0] = int'(sticky_a); obs_sticky[1] = int'(sticky_b);
      obs_sticky[2] = int'(sticky_c);
      obs_fcnt[0] = int'(fcnt_a); obs_fcnt[1] = int'(fcnt_b); obs_fcnt[2] = int'(fcnt_c);
      obs_allf[0] = int'(allf_a); obs_allf[1] = int'(allf_b); obs_allf[2] = int'(allf_c);
      obs_com[0] = int'(com_a); obs_com[1] = int'(com_b); obs_com[2] = int'(com_c);
      obs_datq[0] = int'(datq_a); obs_datq[1] = int'(datq_b); obs_datq[2] = int'(datq_c);
   end

   // Reference model: offsets as plain integers, lines as modular sums.
   int nl[3] = '{4, 2, 3};
   int fl[3] = '{3, 1, 2};
   int m_temp[3], m_sticky[3], m_fcnt[3], m_allf[3], m_act[3];

   function automatic int base_of(int k);
      int b;
      b = (k == 1) ? int'(base[0]) : int'(base);
      return (b >= nl[k]) ? 0 : b;
   endfunction

   function automatic void mreset();
      for (int k = 0; k < 3; k++) begin
         m_temp[k] = 0; m_sticky[k] = 0; m_fcnt[k] = 0; m_allf[k] = 0; m_act[k] = 0;
      end
   endfunction

   function automatic void mstep(int k);
      if (sync_clr) begin
         m_temp[k] = 0; m_sticky[k] = 0; m_fcnt[k] = 0; m_allf[k] = 0;
      end else if (switch_req) begin
         m_fcnt[k] = m_fcnt[k] + 1;
         if (m_fcnt[k] == fl[k]) begin
            m_fcnt[k]   = 0;
            m_temp[k]   = 0;
            m_sticky[k] = (m_sticky[k] + 1) % nl[k];
            if (m_sticky[k] == 0) m_allf[k] = 1;
         end else begin
            m_temp[k] = (m_temp[k] % (nl[k] - 1)) + 1;
         end
      end else begin
         if (fe) m_temp[k] = 0;
         if (rx_ok) m_fcnt[k] = 0;
      end
      m_act[k] = (base_of(k) + m_sticky[k] + m_temp[k]) % nl[k];
   endfunction

   // One clock with the given single-cycle pulses; outputs settle 1 ns later.
   task automatic cyc(input bit sw, input bit f, input bit ok, input bit clr);
      switch_req = sw; fe = f; rx_ok = ok; sync_clr = clr;
      @(posedge clk);
      for (int k = 0; k < 3; k++) mstep(k);
      #1;
      switch_req = 0; fe = 0; rx_ok = 0; sync_clr = 0;
   endtask

   task automatic test_reset();
      n_rst = 0; sync_clr = 0; base = 2'd2; switch_req = 0; fe = 0; rx_ok = 0;
      cd_q = 0; dat = 4'h0;
      mreset();
      #12;
      checks++;
      if (snap_a !== 10'b0) begin
         errors++; $display("FAIL reset_state: got %b want %b", snap_a, 10'b0);
      end
      checks++;
      if (com_a !== 4'b1110) begin
         errors++; $display("FAIL reset_com_cd0: got %b want %b", com_a, 4'b1110);
      end
      cd_q = 1; #1;
      checks++;
      if (com_a !== 4'b1111) begin
         errors++; $display("FAIL reset_com_cd1: got %b want %b", com_a, 4'b1111);
      end
      @(negedge clk);
      n_rst = 1; cd_q = 0;
      cyc(0, 0, 0, 0);
      checks++;
      if (act_a !== 2'd2 || com_a !== 4'b1011) begin
         errors++;
         $display("FAIL first_edge: got act %0d com %b want act 2 com 1011", act_a, com_a);
      end
      dat = 4'b0100; #1;
      checks++;
      if (datq_a !== 1'b1) begin
         errors++; $display("FAIL datq_hi: got %b want 1", datq_a);
      end
      dat = 4'b1011; #1;
      checks++;
      if (datq_a !== 1'b0) begin
         errors++; $display("FAIL datq_lo: got %b want 0", datq_a);
      end
   endtask

   // Home line 2: one temporary exchange on 3, then back, then a good reply.
   task automatic test_temp_switch();
      bit   [2:0] stim[4] = '{3'b100, 3'b000, 3'b010, 3'b001};
      logic [9:0] expv[4] = '{{2'd3, 1'b1, 2'd0, 4'd1, 1'b0},
                              {2'd3, 1'b1, 2'd0, 4'd1, 1'b0},
                              {2'd2, 1'b0, 2'd0, 4'd1, 1'b0},
                              {2'd2, 1'b0, 2'd0, 4'd0, 1'b0}};
      for (int i = 0; i < 4; i++) begin
         cyc(stim[i][2], stim[i][1], stim[i][0], 0);
         checks++;
         if (snap_a !== expv[i]) begin
            errors++; $display("FAIL temp_switch[%0d]: got %b want %b", i, snap_a, expv[i]);
         end
      end
   endtask

   // Walk of temporary lines 3,0,1,3 never lands on home 2.
   task automatic test_temp_walk();
      bit   [2:0] stim[7] = '{3'b100, 3'b100, 3'b001, 3'b100, 3'b100, 3'b001, 3'b010};
      logic [9:0] expv[7] = '{{2'd3, 1'b1, 2'd0, 4'd1, 1'b0},
                              {2'd0, 1'b1, 2'd0, 4'd2, 1'b0},
                              {2'd0, 1'b1, 2'd0, 4'd0, 1'b0},
                              {2'd1, 1'b1, 2'd0, 4'd1, 1'b0},
                              {2'd3, 1'b1, 2'd0, 4'd2, 1'b0},
                              {2'd3, 1'b1, 2'd0, 4'd0, 1'b0},
                              {2'd2, 1'b0, 2'd0, 4'd0, 1'b0}};
      for (int i = 0; i < 7; i++) begin
         cyc(stim[i][2], stim[i][1], stim[i][0], 0);
         checks++;
         if (snap_a !== expv[i]) begin
            errors++; $display("FAIL temp_walk[%0d]: got %b want %b", i, snap_a, expv[i]);
         end
      end
   endtask

   // Three failed exchanges make the move to line 3 permanent.
   task automatic test_sticky();
      bit   [2:0] stim[6] = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
      logic [9:0] expv[6] = '{{2'd3, 1'b1, 2'd0, 4'd1, 1'b0},
                              {2'd2, 1'b0, 2'd0, 4'd1, 1'b0},
                              {2'd3, 1'b1, 2'd0, 4'd2, 1'b0},
                              {2'd2, 1'b0, 2'd0, 4'd2, 1'b0},
                              {2'd3, 1'b0, 2'd1, 4'd0, 1'b0},
                              {2'd3, 1'b0, 2'd1, 4'd0, 1'b0}};
      for (int i = 0; i < 6; i++) begin
         cyc(stim[i][2], stim[i][1], stim[i][0], 0);
         checks++;
         if (snap_a !== expv[i]) begin
            errors++; $display("FAIL sticky[%0d]: got %b want %b", i, snap_a, expv[i]);
         end
      end
   endtask

   // switch_req wins over frame_to_reply_end and over rx_ok in the same cycle.
   task automatic test_coincident();
      bit   [2:0] stim[4] = '{3'b110, 3'b101, 3'b010, 3'b001};
      logic [9:0] expv[4] = '{{2'd0, 1'b1, 2'd1, 4'd1, 1'b0},
                              {2'd1, 1'b1, 2'd1, 4'd2, 1'b0},
                              {2'd3, 1'b0, 2'd1, 4'd2, 1'b0},
                              {2'd3, 1'b0, 2'd1, 4'd0, 1'b0}};
      for (int i = 0; i < 4; i++) begin
         cyc(stim[i][2], stim[i][1], stim[i][0], 0);
         checks++;
         if (snap_a !== expv[i]) begin
            errors++; $display("FAIL coincident[%0d]: got %b want %b", i, snap_a, expv[i]);
         end
      end
   endtask

   // Two lines, limit 1: two failures exhaust both lines; sync_clr recovers.
   task automatic test_all_failed();
      bit   [3:0] stim[5] = '{4'b0001, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
      logic [7:0] expv[5] = '{{1'd0, 1'b0, 1'd0, 4'd0, 1'b0},
                              {1'd1, 1'b0, 1'd1, 4'd0, 1'b0},
                              {1'd0, 1'b0, 1'd0, 4'd0, 1'b1},
                              {1'd0, 1'b0, 1'd0, 4'd0, 1'b1},
                              {1'd1, 1'b0, 1'd1, 4'd0, 1'b1}};
      base = 2'd2;
      for (int i = 0; i < 5; i++) begin
         cyc(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
         checks++;
         if (snap_b !== expv[i]) begin
            errors++; $display("FAIL all_failed[%0d]: got %b want %b", i, snap_b, expv[i]);
         end
      end
      base = 2'd3;
      cyc(0, 0, 0, 1);
      checks++;
      if (snap_b !== {1'd1, 1'b0, 1'd0, 4'd0, 1'b0}) begin
         errors++; $display("FAIL sync_clr_b: got %b want %b", snap_b, 8'b10000000);
      end
      checks++;
      if (snap_a !== {2'd3, 1'b0, 2'd0, 4'd0, 1'b0}) begin
         errors++; $display("FAIL sync_clr_a: got %b want %b", snap_a, 10'b1100000000);
      end
      // Three lines: base_line 3 is out of range and selects line 0.
      checks++;
      if (snap_c !== 10'b0) begin
         errors++; $display("FAIL base_oob_c: got %b want %b", snap_c, 10'b0);
      end
   endtask

   // base_line changes mid-exchange move act_line but leave the counters.
   task automatic test_base_change();
      cyc(1, 0, 0, 0);
      checks++;
      if (snap_c !== {2'd1, 1'b1, 2'd0, 4'd1, 1'b0}) begin
         errors++; $display("FAIL base_pre_c: got %b want %b", snap_c, 10'b0110000010);
      end
      base = 2'd1;
      cyc(0, 0, 0, 0);
      checks++;
      if (snap_a !== {2'd2, 1'b1, 2'd0, 4'd1, 1'b0} ||
          snap_c !== {2'd2, 1'b1, 2'd0, 4'd1, 1'b0}) begin
         errors++; $display("FAIL base_change: got a %b c %b want both %b",
                            snap_a, snap_c, 10'b1010000010);
      end
      cyc(0, 1, 1, 0);
   endtask

   // Asynchronous reset mid-exchange drops straight to line 0.
   task automatic test_async_reset();
      cyc(1, 0, 0, 0);
      cd_q = 0;
      n_rst = 0; #1;
      mreset();
      checks++;
      if (snap_a !== 10'b0 || com_a !== 4'b1110) begin
         errors++; $display("FAIL async_reset: got %b com %b want %b com 1110",
                            snap_a, com_a, 10'b0);
      end
      @(negedge clk);
      n_rst = 1;
   endtask

   task automatic test_random();
      int e_com;
      for (int c = 0; c < 800; c++) begin
         base = 2'($urandom);
         cd_q = 1'($urandom);
         dat  = 4'($urandom);
         cyc(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
             ($urandom % 50) == 0);
         for (int k = 0; k < 3; k++) begin
            e_com = (1 << nl[k]) - 1;
            if (!cd_q) e_com = e_com & ~(1 << m_act[k]);
            checks++;
            if (obs_act[k] != m_act[k] || obs_tmp[k] != int'(m_temp[k] != 0) ||
                obs_sticky[k] != m_sticky[k] || obs_fcnt[k] != m_fcnt[k] ||
                obs_allf[k] != m_allf[k]) begin
               errors++;
               $display("FAIL rand_state c%0d dut%0d: got act %0d tmp %0d sticky %0d fcnt %0d allf %0d want %0d %0d %0d %0d %0d",
                        c, k, obs_act[k], obs_tmp[k], obs_sticky[k], obs_fcnt[k],
                        obs_allf[k], m_act[k], int'(m_temp[k] != 0), m_sticky[k],
                        m_fcnt[k], m_allf[k]);
            end
            checks++;
            if (obs_com[k] != e_com || obs_datq[k] != ((int'(dat) >> m_act[k]) & 1)) begin
               errors++;
               $display("FAIL rand_mux c%0d dut%0d: got com %0h datq %0d want com %0h datq %0d",
                        c, k, obs_com[k], obs_datq[k], e_com,
                        (int'(dat) >> m_act[k]) & 1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_temp_switch();
      test_temp_walk();
      test_sticky();
      test_coincident();
      test_all_failed();
      test_base_change();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
